// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite register file: NUM_REGS byte-strobed registers, independent write/read FSMs,
// SLVERR on out-of-range or misaligned addresses, contents exported flat on reg_out.
module axi4_lite_slave_regfile #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic [2:0]                     awprot,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic [2:0]                     arprot,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // Handshake rule: a transfer occurs on a rising edge where valid and ready are both 1;
    // readies depend only on FSM state and aresetn, never on any valid.
    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  aw_latched, w_latched;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_off, rd_off;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  wr_err, rd_err;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  unused_prot;

    assign unused_prot = ^{awprot, arprot};

    // A handshake in the commit cycle bypasses its holding register.
    assign wr_addr = aw_hs ? awaddr : aw_addr_q;
    assign wr_data = w_hs  ? wdata  : wdata_q;
    assign wr_strb = w_hs  ? wstrb  : wstrb_q;

    assign wr_off = wr_addr - BASE_ADDR;
    assign rd_off = araddr - BASE_ADDR;
    assign wr_idx = wr_off[ADDR_LSB +: IDX_W];
    assign rd_idx = rd_off[ADDR_LSB +: IDX_W];
    assign wr_err = (wr_addr < BASE_ADDR) || (wr_off[ADDR_LSB-1:0] != '0) ||
                    ((wr_off >> ADDR_LSB) >= ADDR_WIDTH'(NUM_REGS));
    assign rd_err = (araddr < BASE_ADDR) || (rd_off[ADDR_LSB-1:0] != '0) ||
                    ((rd_off >> ADDR_LSB) >= ADDR_WIDTH'(NUM_REGS));

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign bvalid = (w_state == W_RESP);
    assign rvalid = (r_state == R_DATA);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        commit  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = aresetn && !aw_latched;
                wready  = aresetn && !w_latched;
                if ((aw_latched || aw_hs) && (w_latched || w_hs)) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: if (bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = aresetn;
                if (ar_hs) r_next = R_DATA;
            end
            R_DATA: if (rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_latched <= 1'b0;
            w_latched  <= 1'b0;
            aw_addr_q  <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp      <= 2'b00;
            wr_pulse   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                aw_latched <= 1'b0;
                w_latched  <= 1'b0;
                bresp      <= wr_err ? 2'b10 : 2'b00;
                if (!wr_err) begin
                    wr_pulse <= NUM_REGS'(1) << wr_idx;
                    for (int b = 0; b < STRB_W; b++)
                        if (wr_strb[b]) regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end else begin
                if (aw_hs) begin
                    aw_latched <= 1'b1;
                    aw_addr_q  <= awaddr;
                end
                if (w_hs) begin
                    w_latched <= 1'b1;
                    wdata_q   <= wdata;
                    wstrb_q   <= wstrb;
                end
            end
        end
    end

    // Sampling regs here on the commit edge naturally yields the pre-write value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata <= '0;
            rresp <= 2'b00;
        end else if (ar_hs) begin
            rdata <= rd_err ? '0 : regs[rd_idx];
            rresp <= rd_err ? 2'b10 : 2'b00;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
endmodule
